// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam int          PC_STEP = 4;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: enable-gated load, synchronous bubble, async clear.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         bubble,
    input  logic [N-1:0] instr_d,
    input  logic [N-1:0] pc4_d,
    input  logic         valid_d,
    output logic [N-1:0] instr,
    output logic [N-1:0] pc4,
    output logic         valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= N'(NOP);
            pc4   <= '0;
            valid <= 1'b0;
        end else if (en) begin
            if (bubble) begin
                instr <= N'(NOP);
                pc4   <= '0;
                valid <= 1'b0;
            end else begin
                instr <= instr_d;
                pc4   <= pc4_d;
                valid <= valid_d;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-cycle-latency imem interface, redirect squash, redirect counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             pcsrc,
    input  logic [N-1:0]     branch_target,
    output logic [N-1:0]     imem_addr,
    output logic             imem_en,
    input  logic [N-1:0]     imem_rdata,
    output logic [N-1:0]     if_id_instr,
    output logic [N-1:0]     if_id_pc4,
    output logic             if_id_valid,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_cnt
);
    fetch_state_e     state_q, state_d;
    logic [N-1:0]     pc_q, pc_d;
    logic [N-1:0]     fetched_pc_q, fetched_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en;
    logic             bubble;
    logic [N-1:0]     target;
    logic             unused_tgt_lsbs;

    // Low address bits of the target are forced to word alignment.
    assign target          = {branch_target[N-1:2], 2'b00};
    assign unused_tgt_lsbs = ^branch_target[1:0];

    assign en           = ~stall | pcsrc;
    assign imem_en      = en;
    assign imem_addr    = pc_q;
    assign flush        = pcsrc;
    assign redirect_cnt = cnt_q;

    // A word returning during FILL was issued on the wrong path (or before reset).
    assign bubble = pcsrc | (state_q == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            pc_q         <= RESET_PC;
            fetched_pc_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetched_pc_q <= fetched_pc_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetched_pc_d = fetched_pc_q;
        cnt_d        = cnt_q;
        if (pcsrc) begin
            state_d = FILL;
            pc_d    = target;
            if (cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end else if (!stall) begin
            state_d      = RUN;
            fetched_pc_d = pc_q;
            pc_d         = pc_q + N'(PC_STEP);
        end
    end

    if_id_reg #(.N(N)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .bubble  (bubble),
        .instr_d (imem_rdata),
        .pc4_d   (fetched_pc_q + N'(PC_STEP)),
        .valid_d (1'b1),
        .instr   (if_id_instr),
        .pc4     (if_id_pc4),
        .valid   (if_id_valid)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a fetch-stream reference model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, pcsrc;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_en;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid, flush;
    logic [15:0] redirect_cnt;

    logic [31:0] s_addr, s_instr, s_pc4;
    logic        s_en, s_valid, s_flush;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    fetch_unit #(.N(32), .RESET_PC(RESET_PC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .flush(flush), .redirect_cnt(redirect_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    fetch_unit #(.N(32), .RESET_PC(RESET_PC), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .imem_addr(s_addr), .imem_en(s_en),
        .imem_rdata(imem_rdata), .if_id_instr(s_instr), .if_id_pc4(s_pc4),
        .if_id_valid(s_valid), .flush(s_flush), .redirect_cnt(s_cnt)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    always @(posedge clk)
        if (imem_en) imem_rdata <= word_at(imem_addr);

    typedef struct {
        logic [31:0] addr;
        logic        en;
        logic        flush;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference: a fetch issued on an enabled, non-redirect cycle returns a good word.
    logic [31:0] m_pc, m_ret_addr, m_instr, m_pc4;
    logic        m_ret_ok, m_valid;
    int          m_cnt;

    task automatic model_reset();
        m_pc = RESET_PC; m_ret_addr = '0; m_ret_ok = 1'b0;
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step(input logic st, input logic ps, input logic [31:0] tg);
        if (ps) begin
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
            m_ret_ok = 1'b0;
            m_pc = tg & 32'hFFFF_FFFC;
            m_cnt++;
        end else if (!st) begin
            if (m_ret_ok) begin
                m_instr = word_at(m_ret_addr); m_pc4 = m_ret_addr + 32'd4; m_valid = 1'b1;
            end else begin
                m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
            end
            m_ret_addr = m_pc; m_ret_ok = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cyc(input logic rst, input logic st, input logic ps, input logic [31:0] tg);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = ~rst; stall = st; pcsrc = ps; branch_target = tg;
        if (rst) model_reset();
        e.addr = m_pc; e.en = ~st | ps; e.flush = ps;
        e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
        exp_q.push_back(e);
        if (!rst) model_step(st, ps, tg);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int   c16, c2;
            e = exp_q.pop_front();
            c16 = (e.cnt > 65535) ? 65535 : e.cnt;
            c2  = (e.cnt > 3) ? 3 : e.cnt;
            chk("imem_addr", imem_addr, e.addr);
            chk("imem_en", {31'd0, imem_en}, {31'd0, e.en});
            chk("flush", {31'd0, flush}, {31'd0, e.flush});
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_pc4", if_id_pc4, e.pc4);
            chk("redirect_cnt", {16'd0, redirect_cnt}, c16[31:0]);
            chk("sat_addr", s_addr, e.addr);
            chk("sat_en", {31'd0, s_en}, {31'd0, e.en});
            chk("sat_flush", {31'd0, s_flush}, {31'd0, e.flush});
            chk("sat_valid", {31'd0, s_valid}, {31'd0, e.valid});
            chk("sat_instr", s_instr, e.instr);
            chk("sat_pc4", s_pc4, e.pc4);
            chk("sat_cnt", {30'd0, s_cnt}, c2[31:0]);
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; pcsrc = 1'b0; branch_target = '0;
        model_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        // Reset release and straight-line fetch up to PC=0x10.
        repeat (4) cyc(0, 0, 0, 0);
        // Stall 3 cycles, then resume.
        repeat (3) cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        // Redirect to an unaligned target.
        cyc(0, 0, 1, 32'h43);
        repeat (4) cyc(0, 0, 0, 0);
        // Redirect concurrent with stall, stall held two more cycles.
        cyc(0, 1, 1, 32'h200);
        repeat (2) cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        // Back-to-back redirects; also saturates the 2-bit counter.
        cyc(0, 0, 1, 32'h80);
        cyc(0, 0, 1, 32'hC0);
        repeat (5) cyc(0, 0, 0, 0);
        // PC wrap past the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        repeat (4) cyc(0, 0, 0, 0);
        // Reset in the middle of a FILL.
        cyc(0, 0, 1, 32'h300);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            int unsigned r;
            logic        rr, st, ps;
            logic [31:0] tg;
            r  = $urandom_range(0, 99);
            rr = ($urandom_range(0, 299) == 0);
            st = (r < 25);
            ps = ($urandom_range(0, 9) == 0);
            tg = ($urandom_range(0, 3) == 0) ? $urandom : {20'd0, 12'($urandom)};
            cyc(rr, st, ps, tg);
        end
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
